// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, instruction field positions and decode helper for the hazard unit
package hazard_pkg;
  localparam logic [3:0] OP_R   = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b0100;
  localparam logic [3:0] OP_NOP = 4'b1100;
  localparam logic [15:0] NOP_INSTR = 16'hC000;
  localparam int OP_HI = 15, OP_LO = 12;
  localparam int RS_HI = 11, RS_LO = 9;
  localparam int RT_HI = 8, RT_LO = 6;
  localparam int RD_HI = 5, RD_LO = 3;
  localparam int REG_NUM = 8;
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] dst;
    logic [2:0] rs;
    logic [2:0] rt;
  } dec_t;
  // Unused register fields decode as r0, which the scoreboard treats as always ready.
  function automatic dec_t decode(input logic [15:0] i);
    dec_t d;
    logic [3:0] op;
    logic wr_rd, rd_rs, rd_rt;
    op = i[OP_HI:OP_LO];
    wr_rd = (op == OP_R) || (op == OP_MUL);
    rd_rt = wr_rd || (op == OP_SW) || (op == OP_BEQ);
    rd_rs = rd_rt || (op == OP_LW);
    d.op = op;
    d.rs = rd_rs ? i[RS_HI:RS_LO] : 3'd0;
    d.rt = rd_rt ? i[RT_HI:RT_LO] : 3'd0;
    d.dst = wr_rd ? i[RD_HI:RD_LO] : (op == OP_LW) ? i[RT_HI:RT_LO] : 3'd0;
    return d;
  endfunction
endpackage

// File: rtl/hz_scoreboard.sv
// hz_scoreboard: per-register cycles-until-writeback counters with two source lookups
module hz_scoreboard
  import hazard_pkg::*;
#(
  parameter int WB_LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_dst,
  input  logic [2:0] src_a,
  input  logic [2:0] src_b,
  output logic       rdy_a,
  output logic       rdy_b
);
  logic [3:0] sb_cnt [REG_NUM];
  // A fresh issue reloads the counter; otherwise counters drain toward zero. r0 stays 0.
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < REG_NUM; r++)
      sb_cnt[r] <= (!rst_n || r == 0) ? 4'd0 :
                   (wr_en && wr_dst == 3'(r)) ? 4'(WB_LAT) :
                   (sb_cnt[r] != 4'd0) ? sb_cnt[r] - 4'd1 : 4'd0;
  end
  // The register file writes in the first half-cycle, so a count of 1 is already ready.
  always_comb begin
    rdy_a = sb_cnt[src_a] <= 4'd1;
    rdy_b = sb_cnt[src_b] <= 4'd1;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage stall/flush generation for the 16-bit pipeline
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FWD_EN    = 1,
  parameter int WB_LAT    = 3,
  parameter int FLUSH_CYC = 1,
  parameter int MUL_CYC   = 4
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [15:0] instr_id_i,
  input  logic        branch_taken_i,
  output logic        DHZ_o,
  output logic        CHZ_o,
  output logic        bubble_idex_o,
  output logic        issue_o
);
  dec_t       d;
  logic       ld_pend;
  logic [2:0] ld_dst;
  logic [3:0] mul_cnt;
  logic [1:0] flush_cnt;
  logic       rdy_a, rdy_b, raw_stall, chz, dhz;
  hz_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .wr_en (issue_o && FWD_EN == 0 && d.dst != 3'd0),
    .wr_dst(d.dst),
    .src_a (d.rs),
    .src_b (d.rt),
    .rdy_a (rdy_a),
    .rdy_b (rdy_b)
  );
  // Hazard decisions are combinational on the IF/ID instruction; flush overrides stall.
  always_comb begin
    d = decode(instr_id_i);
    raw_stall = (FWD_EN != 0) ?
      ld_pend && ld_dst != 3'd0 && (ld_dst == d.rs || ld_dst == d.rt) :
      !(rdy_a && rdy_b);
    chz = branch_taken_i || flush_cnt != 2'd0;
    dhz = !chz && (raw_stall || mul_cnt != 4'd0);
    CHZ_o = rst_n && chz;
    DHZ_o = rst_n && dhz;
    bubble_idex_o = !rst_n || chz || dhz;
    issue_o = !bubble_idex_o;
  end
  // Load-use marker, MUL busy and flush counters; only an issued instruction updates them.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ld_pend <= 1'b0;
      ld_dst <= 3'd0;
      mul_cnt <= 4'd0;
      flush_cnt <= 2'd0;
    end else begin
      ld_pend <= FWD_EN != 0 && issue_o && d.op == OP_LW && d.dst != 3'd0;
      ld_dst <= d.dst;
      mul_cnt <= (issue_o && d.op == OP_MUL) ? 4'(MUL_CYC - 1) :
                 (mul_cnt != 4'd0) ? mul_cnt - 4'd1 : 4'd0;
      flush_cnt <= branch_taken_i ? 2'(FLUSH_CYC - 1) :
                   (flush_cnt != 2'd0) ? flush_cnt - 2'd1 : 2'd0;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of a forwarding and a non-forwarding hazard_ctrl
module tb_hazard_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        br;
  logic [15:0] instr_a, instr_b;
  logic        dhz_a, chz_a, bub_a, iss_a;
  logic        dhz_b, chz_b, bub_b, iss_b;
  int checks = 0;
  int errors = 0;
  localparam logic [3:0] ST = 4'b1010, FL = 4'b0110, IS = 4'b0001, RS = 4'b0010;
  localparam logic [15:0] NOP = 16'hC000;
  localparam logic [15:0] LW_R2 = 16'h8080;
  localparam logic [15:0] ADD_R3_R2_R1 = 16'h0458;
  localparam logic [15:0] ADD_R1 = 16'h0008;
  localparam logic [15:0] SUB_R2_R1 = 16'h0210;
  localparam logic [15:0] ADD_R0 = 16'h0000;
  localparam logic [15:0] SUB_R3_R0 = 16'h0018;
  localparam logic [15:0] MUL_R4 = 16'h3260;

  hazard_ctrl #(.FWD_EN(1), .WB_LAT(3), .FLUSH_CYC(2), .MUL_CYC(4)) dut_a (
    .clk_i(clk_i), .rst_n(rst_n), .instr_id_i(instr_a), .branch_taken_i(br),
    .DHZ_o(dhz_a), .CHZ_o(chz_a), .bubble_idex_o(bub_a), .issue_o(iss_a));
  hazard_ctrl #(.FWD_EN(0), .WB_LAT(3), .FLUSH_CYC(2), .MUL_CYC(4)) dut_b (
    .clk_i(clk_i), .rst_n(rst_n), .instr_id_i(instr_b), .branch_taken_i(br),
    .DHZ_o(dhz_b), .CHZ_o(chz_b), .bubble_idex_o(bub_b), .issue_o(iss_b));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s {DHZ,CHZ,bubble,issue} observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic both(input string tag, input logic [3:0] ea, input logic [3:0] eb);
    @(negedge clk_i);
    chk({tag, "_a"}, {dhz_a, chz_a, bub_a, iss_a}, ea);
    chk({tag, "_b"}, {dhz_b, chz_b, bub_b, iss_b}, eb);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; br = 1'b0; instr_a = NOP; instr_b = NOP;
    both("reset", RS, RS);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) both("nop_stream", IS, IS);
    instr_a = LW_R2;
    both("t1_lw", IS, IS);
    instr_a = ADD_R3_R2_R1;
    both("t1_loaduse", ST, IS);
    both("t1_release", IS, IS);
    instr_a = NOP;
    instr_b = ADD_R1;
    both("t2_add", IS, IS);
    instr_b = SUB_R2_R1;
    both("t2_raw1", IS, ST);
    both("t2_raw2", IS, ST);
    both("t2_release", IS, IS);
    instr_b = ADD_R0;
    both("t2_r0_dst", IS, IS);
    instr_b = SUB_R3_R0;
    both("t2_r0_src", IS, IS);
    instr_a = LW_R2; instr_b = ADD_R1;
    both("t3_setup", IS, IS);
    instr_a = ADD_R3_R2_R1; instr_b = SUB_R2_R1; br = 1'b1;
    both("t3_flush1", FL, FL);
    br = 1'b0;
    both("t3_flush2", FL, FL);
    both("t3_after", IS, IS);
    instr_a = MUL_R4; instr_b = MUL_R4;
    both("t4_mul", IS, IS);
    instr_a = NOP; instr_b = NOP;
    both("t4_busy1", ST, ST);
    both("t4_busy2", ST, ST);
    both("t4_busy3", ST, ST);
    both("t4_release", IS, IS);
    instr_a = MUL_R4; instr_b = MUL_R4;
    both("t5_mul", IS, IS);
    instr_a = NOP; instr_b = NOP; br = 1'b1;
    both("t5_flush", FL, FL);
    br = 1'b0; rst_n = 1'b0;
    both("t5_in_reset", RS, RS);
    rst_n = 1'b1;
    both("t5_after_reset", IS, IS);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
